id_regfile_sb: RTL and testbench

//  Parametrised decode-stage register file with a write-back scoreboard, for the pipelined MIPS core.

---
 rtl/id_regfile_sb.sv | 135 +++++++++++++
 tb/tb_id_regfile_sb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_regfile_sb.sv
// Decode-stage GPR file with write-back bypass, R0 tied to zero, HI/LO pair,
// and a scoreboard that stalls issue on RAW/WAW hazards or when too many writes are outstanding.
module id_regfile_sb #(
  parameter int W      = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int MAXPND = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NRD*AW-1:0]                radr,
  input  logic [NRD-1:0]                   rvalid,
  output logic [NRD*W-1:0]                 rdata,
  input  logic                             iss_valid,
  input  logic                             iss_wr,
  input  logic [AW-1:0]                    iss_dst,
  output logic                             iss_ready,
  input  logic                             we,
  input  logic [AW-1:0]                    wadr,
  input  logic [W-1:0]                     wdata,
  input  logic [1:0]                       hilo_we,
  input  logic [W-1:0]                     hi_wdata,
  input  logic [W-1:0]                     lo_wdata,
  output logic [W-1:0]                     hi,
  output logic [W-1:0]                     lo,
  output logic [$clog2(MAXPND+1)-1:0]      pend_cnt
);

  localparam int NREG = 2 ** AW;
  localparam int PW   = $clog2(MAXPND + 1);
  localparam logic [PW-1:0] MAXPND_C = PW'(MAXPND);

  logic [W-1:0]      regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [PW-1:0]     pend_r;
  logic [W-1:0]      hi_r;
  logic [W-1:0]      lo_r;
  logic [NRD*W-1:0]  rdata_s;
  logic [AW-1:0]     ra_s;
  logic              raw_s;
  logic              waw_s;
  logic              cap_s;
  logic              ready_s;
  logic              wr_nz_s;

  // The count never exceeds MAXPND, so truncating to the pend_cnt width is safe.
  function automatic logic [PW-1:0] popcount(input logic [NREG-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return cnt[PW-1:0];
  endfunction

  assign wr_nz_s = we && (wadr != {AW{1'b0}});

  // Read ports: R0 reads zero, a same-cycle write-back is forwarded, otherwise the array.
  always_comb begin
    rdata_s = {NRD*W{1'b0}};
    ra_s    = {AW{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      ra_s = radr[k*AW +: AW];
      if (ra_s == {AW{1'b0}}) begin
        rdata_s[k*W +: W] = {W{1'b0}};
      end else if (we && (wadr == ra_s)) begin
        rdata_s[k*W +: W] = wdata;
      end else begin
        rdata_s[k*W +: W] = regs_r[ra_s];
      end
    end
  end

  // Hazard detection; a write-back landing this cycle resolves the hazard on its register.
  always_comb begin
    raw_s = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      raw_s = raw_s | (rvalid[k] && busy_r[radr[k*AW +: AW]]
                       && !(we && (wadr == radr[k*AW +: AW])));
    end
    waw_s   = iss_wr && busy_r[iss_dst] && !(we && (wadr == iss_dst));
    cap_s   = iss_wr && (iss_dst != {AW{1'b0}}) && (pend_r == MAXPND_C)
              && !(we && busy_r[wadr]);
    ready_s = iss_valid && !(raw_s || waw_s || cap_s) && !RST;
  end

  // Next busy vector: clear on write-back first so a same-cycle issue to that register wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_nz_s) begin
      busy_nxt_s[wadr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (ready_s && iss_wr && (iss_dst != {AW{1'b0}})) begin
      busy_nxt_s[iss_dst] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Register array, HI/LO and scoreboard state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {W{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
      pend_r <= {PW{1'b0}};
      hi_r   <= {W{1'b0}};
      lo_r   <= {W{1'b0}};
    end else begin
      if (wr_nz_s) begin
        regs_r[wadr] <= wdata;
      end
      if (hilo_we[1]) begin
        hi_r <= hi_wdata;
      end
      if (hilo_we[0]) begin
        lo_r <= lo_wdata;
      end
      busy_r <= busy_nxt_s;
      pend_r <= popcount(busy_nxt_s);
    end
  end

  assign rdata     = rdata_s;
  assign iss_ready = ready_s;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign pend_cnt  = pend_r;

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: reset, bypass, R0, RAW/WAW/capacity stalls, HI/LO.
module tb_id_regfile_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  radr;
  logic [1:0]  rvalid;
  logic [63:0] rdata;
  logic        iss_valid, iss_wr, iss_ready;
  logic [4:0]  iss_dst;
  logic        we;
  logic [4:0]  wadr;
  logic [31:0] wdata;
  logic [1:0]  hilo_we;
  logic [31:0] hi_wdata, lo_wdata, hi, lo;
  logic [2:0]  pend_cnt;

  int vecs = 0;
  int errs = 0;

  id_regfile_sb dut (
    .CLK(CLK), .RST(RST), .radr(radr), .rvalid(rvalid), .rdata(rdata),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .we(we), .wadr(wadr), .wdata(wdata), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi(hi), .lo(lo), .pend_cnt(pend_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are changed 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; radr = 10'd0; rvalid = 2'b00;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_dst = 5'd0;
    we = 1'b0; wadr = 5'd0; wdata = 32'd0;
    hilo_we = 2'b00; hi_wdata = 32'd0; lo_wdata = 32'd0;
  endtask

  task automatic issue(input logic [4:0] d);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = d;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    tick(); tick();
    idle();

    // 1: scribble on state, then reset while a write is also requested
    we = 1'b1; wadr = 5'd7; wdata = 32'hA5A5A5A5; hilo_we = 2'b11;
    hi_wdata = 32'h11; lo_wdata = 32'h22; issue(5'd12);
    tick();
    idle(); we = 1'b1; wadr = 5'd5; wdata = 32'h77; issue(5'd13);
    tick();
    idle(); RST = 1'b1; we = 1'b1; wadr = 5'd7; wdata = 32'hFFFF0000; issue(5'd14);
    #2 chk("rst_iss_ready_low", iss_ready, 1'b0);
    tick();
    idle(); radr = {5'd5, 5'd7}; iss_valid = 1'b1;
    #2;
    chk("rst_rdata0", rdata[31:0], 32'd0);
    chk("rst_rdata1", rdata[63:32], 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_pend", pend_cnt, 3'd0);
    chk("rst_iss_ready", iss_ready, 1'b1);
    tick();

    // 2: bypass then committed read
    idle(); we = 1'b1; wadr = 5'd5; wdata = 32'hDEADBEEF; radr = {5'd0, 5'd5};
    #2 chk("bypass_same", rdata[31:0], 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #2 chk("bypass_next", rdata[31:0], 32'hDEADBEEF);
    tick();

    // 3: R0 is never written
    idle(); we = 1'b1; wadr = 5'd0; wdata = 32'hFFFFFFFF; radr = {5'd0, 5'd0};
    #2 chk("r0_same", rdata[31:0], 32'd0);
    tick();
    we = 1'b0;
    #2 chk("r0_next", rdata[31:0], 32'd0);
    tick();

    // 4: RAW stall on r8 released by its write-back
    idle(); issue(5'd8);
    #2 chk("iss8_ready", iss_ready, 1'b1);
    tick();
    idle(); iss_valid = 1'b1; radr = {5'd0, 5'd8};
    #2 chk("rvalid_gated", iss_ready, 1'b1);
    rvalid = 2'b01;
    #2 chk("raw_stall", iss_ready, 1'b0);
    chk("pend_one", pend_cnt, 3'd1);
    tick();
    we = 1'b1; wadr = 5'd8; wdata = 32'h12345678;
    #2 chk("raw_release", iss_ready, 1'b1);
    chk("raw_bypass", rdata[31:0], 32'h12345678);
    tick();
    idle();
    #2 chk("pend_zero", pend_cnt, 3'd0);
    tick();

    // 5: fill the scoreboard, then capacity stall
    for (int d = 1; d <= 4; d++) begin
      idle(); issue(5'(d));
      tick();
    end
    idle();
    #2 chk("pend_full", pend_cnt, 3'd4);
    issue(5'd9);
    #2 chk("cap_stall", iss_ready, 1'b0);
    iss_dst = 5'd0;
    #2 chk("dst0_no_cap", iss_ready, 1'b1);
    tick();
    #2 chk("dst0_no_busy", pend_cnt, 3'd4);
    iss_dst = 5'd9; we = 1'b1; wadr = 5'd2; wdata = 32'h55;
    #2 chk("cap_release", iss_ready, 1'b1);
    tick();
    idle();
    #2 chk("pend_swap", pend_cnt, 3'd4);
    issue(5'd9);
    #2 chk("waw_stall", iss_ready, 1'b0);

    // write-back to a non-busy register leaves the scoreboard alone
    idle(); we = 1'b1; wadr = 5'd20; wdata = 32'h20;
    tick();
    idle();
    #2 chk("nonbusy_wb", pend_cnt, 3'd4);

    // 6: set wins over a same-cycle clear of the same register
    issue(5'd3); we = 1'b1; wadr = 5'd3; wdata = 32'h33;
    #2 chk("iss3_ready", iss_ready, 1'b1);
    tick();
    idle(); iss_valid = 1'b1; rvalid = 2'b10; radr = {5'd3, 5'd0};
    #2 chk("pend_keep", pend_cnt, 3'd4);
    chk("busy3_held", iss_ready, 1'b0);
    chk("r3_data", rdata[63:32], 32'h33);
    tick();

    idle(); hilo_we = 2'b11; hi_wdata = 32'd1; lo_wdata = 32'd2;
    #2 chk("hi_no_bypass", hi, 32'd0);
    tick();
    idle();
    #2 chk("hi_written", hi, 32'd1);
    chk("lo_written", lo, 32'd2);
    hilo_we = 2'b01; hi_wdata = 32'd9; lo_wdata = 32'd7;
    tick();
    idle();
    #2 chk("hi_kept", hi, 32'd1);
    chk("lo_only", lo, 32'd7);

    RST = 1'b1;
    tick();
    idle();
    #2 chk("final_rst_pend", pend_cnt, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
